mem_stage_responder: RTL and testbench

- Data-memory responder for the MEM stage of the 64-bit pipeline.
- Accepts one load or store request at a time, carrying the core's mem_load_type_t / mem_store_type_t encodings and sign flags.
- Services each request after a configurable wait-state latency from an internal 64-bit-wide array, and returns formatted load data or an address-error flag.
- Drives a stall that freezes the pipeline while a request is outstanding.

---
 rtl/mem_stage_responder.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_responder.sv
`timescale 1ns/1ps
// mem_stage_responder: MEM-stage data-memory responder.
// Accepts one load/store at a time, waits LATENCY edges, then commits the
// store or returns formatted load data (or an address error) for one cycle.
// Ports:
//   clock, reset         rising-edge clock, async active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   addr, load_type, store_type, signed_byte, signed_word, wdata  request
//   resp_valid, rdata, addr_error  one-cycle response
//   stall                pipeline hold while a request is pending
module mem_stage_responder #(
  parameter int unsigned DWORDS  = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] addr,
  input  logic [1:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic        signed_byte,
  input  logic        signed_word,
  input  logic [63:0] wdata,
  output logic        resp_valid,
  output logic [63:0] rdata,
  output logic        addr_error,
  output logic        stall
);

  localparam int unsigned IDX_W = (DWORDS > 1) ? $clog2(DWORDS) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [63:0]        r_addr;
  logic [1:0]         r_ld;
  logic [1:0]         r_st;
  logic               r_sb;
  logic               r_sw;
  logic [63:0]        r_wdata;
  logic               r_resp_valid;
  logic [63:0]        r_rdata;
  logic               r_addr_error;
  logic [63:0]        r_mem [DWORDS];

  logic               w_active;
  logic               w_accept;
  logic               w_enter_resp;
  logic [1:0]         w_size;
  logic               w_err;
  logic [IDX_W-1:0]   w_idx;
  logic [63:0]        w_rd_raw;
  logic [63:0]        w_wr_data;
  logic [63:0]        w_ld_data;
  logic [7:0]         w_byte;
  logic [31:0]        w_word;

  assign w_active     = req_valid && ((load_type != 2'd0) || (store_type != 2'd0));
  assign w_accept     = (r_state == S_IDLE) && w_active;
  // r_cnt holds the remaining WAIT edges; RESP is entered on the edge where it
  // reads zero, so every request spends exactly LATENCY edges before RESP.
  assign w_enter_resp = (r_state == S_WAIT) && (r_cnt == '0);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, handshake and stall
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        stall     = w_active;
        if (w_active) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture and wait-state counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_ld    <= '0;
      r_st    <= '0;
      r_sb    <= 1'b0;
      r_sw    <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= CNT_W'(LATENCY - 1);
      r_addr  <= addr;
      r_ld    <= load_type;
      r_st    <= store_type;
      r_sb    <= signed_byte;
      r_sw    <= signed_word;
      r_wdata <= wdata;
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Error checks on the captured request
  assign w_size = (r_ld != 2'd0) ? r_ld : r_st;
  assign w_err  = ((r_ld != 2'd0) && (r_st != 2'd0))
               || ((w_size == 2'd2) && (r_addr[1:0] != 2'd0))
               || ((w_size == 2'd3) && (r_addr[2:0] != 3'd0))
               || (r_addr[63:3] >= 61'(DWORDS));

  assign w_idx    = r_addr[IDX_W+2:3];
  assign w_rd_raw = r_mem[w_idx];
  assign w_byte   = w_rd_raw[{r_addr[2:0], 3'b000} +: 8];
  assign w_word   = w_rd_raw[{r_addr[2], 5'b00000} +: 32];

  // Little-endian lane merge for stores
  always_comb begin
    w_wr_data = w_rd_raw;
    case (r_st)
      2'd1:    w_wr_data[{r_addr[2:0], 3'b000} +: 8] = r_wdata[7:0];
      2'd2:    w_wr_data[{r_addr[2], 5'b00000} +: 32] = r_wdata[31:0];
      2'd3:    w_wr_data = r_wdata;
      default: ;
    endcase
  end

  // Load lane select and extension
  always_comb begin
    w_ld_data = '0;
    case (r_ld)
      2'd1:    w_ld_data = {{56{r_sb & w_byte[7]}}, w_byte};
      2'd2:    w_ld_data = {{32{r_sw & w_word[31]}}, w_word};
      2'd3:    w_ld_data = w_rd_raw;
      default: w_ld_data = '0;
    endcase
  end

  // Store commit on the edge entering RESP; contents are never reset
  always_ff @(posedge clock) begin
    if (w_enter_resp && !w_err && (r_st != 2'd0)) r_mem[w_idx] <= w_wr_data;
  end

  // Registered response, valid only in the RESP cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_addr_error <= 1'b0;
    end else begin
      r_resp_valid <= w_enter_resp;
      r_rdata      <= (w_enter_resp && !w_err) ? w_ld_data : '0;
      r_addr_error <= w_enter_resp && w_err;
    end
  end

  assign resp_valid = r_resp_valid;
  assign rdata      = r_rdata;
  assign addr_error = r_addr_error;

endmodule

// File: tb/tb_mem_stage_responder.sv
`timescale 1ns/1ps
// Testbench for mem_stage_responder: byte-level memory model with a
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_mem_stage_responder;

  localparam int unsigned DW  = 512;
  localparam int unsigned LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] addr = '0;
  logic [1:0]  load_type = '0;
  logic [1:0]  store_type = '0;
  logic        signed_byte = 1'b0;
  logic        signed_word = 1'b0;
  logic [63:0] wdata = '0;
  logic        resp_valid;
  logic [63:0] rdata;
  logic        addr_error;
  logic        stall;

  mem_stage_responder #(.DWORDS(DW), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .load_type(load_type), .store_type(store_type),
    .signed_byte(signed_byte), .signed_word(signed_word), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .addr_error(addr_error), .stall(stall)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ne(input string name, input logic [63:0] act, input logic [63:0] bad);
    tests++;
    if (act === bad) begin
      fails++;
      $display("FAIL %s: got %h which must differ from %h", name, act, bad);
    end
  endtask

  // Behavioural model: byte-addressed memory, one outstanding transaction
  logic [7:0]  mb [DW*8];
  bit          busy = 0;
  int          resp_at = 0;
  logic [1:0]  m_ld, m_st;
  logic [63:0] m_a, m_wd;
  logic        m_sb, m_sw;

  function automatic void model_xact(input logic [1:0] ld, input logic [1:0] st,
                                     input logic [63:0] a, input logic [63:0] wd,
                                     input logic sb, input logic sw,
                                     output logic [63:0] rd, output logic er);
    int sel, size, base;
    logic [63:0] v;
    sel  = (ld != 2'd0) ? int'(ld) : int'(st);
    size = (sel == 1) ? 1 : (sel == 2) ? 4 : 8;
    er   = ((ld != 2'd0) && (st != 2'd0)) || (a >= 64'(DW) * 64'd8) ||
           ((a % 64'(size)) != 64'd0);
    rd   = '0;
    if (!er) begin
      base = int'(a[31:0]);
      if (st != 2'd0) begin
        for (int i = 0; i < size; i++) mb[base+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < size; i++) v = v | (64'(mb[base+i]) << (8*i));
        if (size < 8 && ((sel == 1 && sb) || (sel == 2 && sw)) && v[8*size-1])
          v = v - (64'd1 << (8*size));
        rd = v;
      end
    end
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    logic [63:0] e_rd;
    logic        e_er;
    bit          active;
    active = req_valid && ((load_type != 2'd0) || (store_type != 2'd0));
    if (reset) begin
      busy = 0;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_addr_error", addr_error, 0);
      chk("rst_req_ready", req_ready, 1);
    end else begin
      chk("req_ready", req_ready, !busy);
      chk("stall", stall, busy ? (cyc < resp_at) : active);
      chk("resp_valid", resp_valid, busy && (cyc == resp_at));
      if (busy && (cyc == resp_at)) begin
        model_xact(m_ld, m_st, m_a, m_wd, m_sb, m_sw, e_rd, e_er);
        chk("rdata", rdata, e_rd);
        chk("addr_error", addr_error, e_er);
        busy = 0;
      end else if (!busy && active) begin
        busy    = 1;
        resp_at = cyc + 1 + LAT;
        m_ld = load_type; m_st = store_type; m_a = addr; m_wd = wdata;
        m_sb = signed_byte; m_sw = signed_word;
      end
    end
  end

  task automatic drive(input logic [1:0] ld, input logic [1:0] st, input logic [63:0] a,
                       input logic [63:0] wd, input logic sb, input logic sw);
    req_valid = 1'b1; load_type = ld; store_type = st; addr = a; wdata = wd;
    signed_byte = sb; signed_word = sw;
  endtask

  // Drop the request and scramble the payload so capture is exercised
  task automatic scramble();
    req_valid = 1'b0;
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    load_type = 2'($urandom); store_type = 2'($urandom);
    signed_byte = 1'($urandom); signed_word = 1'($urandom);
  endtask

  // Full transaction; call and return at posedge+1
  task automatic xact(input logic [1:0] ld, input logic [1:0] st, input logic [63:0] a,
                      input logic [63:0] wd, input logic sb, input logic sw,
                      output logic [63:0] rd, output logic er);
    bit ok;
    drive(ld, st, a, wd, sb, sw);
    ok = 0;
    repeat (10) begin
      @(negedge clock);
      if (req_ready) begin ok = 1; break; end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clock); #1;
    scramble();
    ok = 0; rd = '0; er = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (resp_valid) begin rd = rdata; er = addr_error; ok = 1; break; end
    end
    chk("resp_timeout", ok, 1);
    @(posedge clock); #1;
  endtask

  logic [63:0] rd;
  logic        er;
  int          nresp;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Prefill the randomized region 0x00..0x3F
    for (int i = 0; i < 8; i++) xact(2'd0, 2'd3, 64'(i*8), {$urandom, $urandom}, 0, 0, rd, er);

    // Reset during WAIT discards the store
    xact(2'd0, 2'd3, 64'h10, 64'h0, 0, 0, rd, er);
    chk("store_rdata_zero", rd, 0);
    drive(2'd0, 2'd3, 64'h10, 64'h1122334455667788, 0, 0);
    @(negedge clock);
    @(posedge clock); #1;
    scramble();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_resp_valid", resp_valid, 0);
    chk("async_rst_rdata", rdata, 0);
    chk("async_rst_addr_error", addr_error, 0);
    chk("async_rst_stall", stall, 0);
    chk("async_rst_ready", req_ready, 1);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    xact(2'd1 + 2'd2, 2'd0, 64'h10, 0, 0, 0, rd, er);
    chk_ne("rst_discard", rd, 64'h1122334455667788);
    chk("rst_discard_val", rd, 64'h0);

    // Byte loads with and without sign extension
    xact(2'd0, 2'd3, 64'h20, 64'h8899AABBCCDDEEFF, 0, 0, rd, er);
    xact(2'd1, 2'd0, 64'h27, 0, 1, 0, rd, er);
    chk("ld_byte_signed", rd, 64'hFFFFFFFFFFFFFF88);
    xact(2'd1, 2'd0, 64'h27, 0, 0, 0, rd, er);
    chk("ld_byte_unsigned", rd, 64'h88);

    // Word store into the upper half, then word and dword reads
    xact(2'd0, 2'd2, 64'h24, 64'hDEADBEEF80000001, 0, 0, rd, er);
    xact(2'd2, 2'd0, 64'h24, 0, 0, 1, rd, er);
    chk("ld_word_signed", rd, 64'hFFFFFFFF80000001);
    xact(2'd3, 2'd0, 64'h20, 0, 0, 0, rd, er);
    chk("ld_dword_merged", rd, 64'h80000001CCDDEEFF);

    // Error cases
    xact(2'd2, 2'd0, 64'h22, 0, 0, 0, rd, er);
    chk("misaligned_word_err", er, 1);
    chk("misaligned_word_rdata", rd, 0);
    xact(2'd0, 2'd3, 64'h0, 64'h0123456789ABCDEF, 0, 0, rd, er);
    xact(2'd3, 2'd3, 64'h0, 64'hFFFFFFFFFFFFFFFF, 0, 0, rd, er);
    chk("both_types_err", er, 1);
    xact(2'd3, 2'd0, 64'h0, 0, 0, 0, rd, er);
    chk("both_types_no_write", rd, 64'h0123456789ABCDEF);
    xact(2'd3, 2'd0, 64'(DW) * 64'd8, 0, 0, 0, rd, er);
    chk("out_of_range_err", er, 1);
    chk("out_of_range_rdata", rd, 0);

    // Cycle-accurate timing of one load (cycle 0 = request presented)
    drive(2'd3, 2'd0, 64'h20, 0, 0, 0);
    @(negedge clock);
    chk("t0_stall", stall, 1); chk("t0_ready", req_ready, 1); chk("t0_resp", resp_valid, 0);
    @(posedge clock); #1 scramble();
    @(negedge clock);
    chk("t1_stall", stall, 1); chk("t1_ready", req_ready, 0); chk("t1_resp", resp_valid, 0);
    @(negedge clock);
    chk("t2_stall", stall, 1); chk("t2_ready", req_ready, 0); chk("t2_resp", resp_valid, 0);
    @(negedge clock);
    chk("t3_stall", stall, 0); chk("t3_ready", req_ready, 0); chk("t3_resp", resp_valid, 1);
    @(negedge clock);
    chk("t4_stall", stall, 0); chk("t4_ready", req_ready, 1); chk("t4_resp", resp_valid, 0);
    @(posedge clock); #1;

    // Null request is ignored
    drive(2'd0, 2'd0, 64'h8, 64'h55, 0, 0);
    nresp = 0;
    repeat (20) begin
      @(negedge clock);
      chk("null_stall", stall, 0);
      if (resp_valid) nresp++;
    end
    chk("null_no_resp", 64'(nresp), 0);
    @(posedge clock); #1 req_valid = 1'b0;

    // Randomized traffic
    repeat (300) begin
      logic [1:0]  ld, st;
      logic [63:0] a;
      int          r;
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 3) == 0) drive(2'd0, 2'd0, {$urandom, $urandom}, 0, 0, 0);
        else req_valid = 1'b0;
        @(posedge clock); #1;
      end
      r  = $urandom_range(0, 7);
      ld = 2'd0; st = 2'd0;
      if (r <= 2 || r == 7) ld = 2'($urandom_range(1, 3));
      else if (r <= 5)      st = 2'($urandom_range(1, 3));
      else begin ld = 2'($urandom_range(1, 3)); st = 2'($urandom_range(1, 3)); end
      if ($urandom_range(0, 15) == 0)
        a = ($urandom_range(0, 1) == 0) ? 64'h1000 + 64'($urandom_range(0, 63)) : {$urandom, $urandom};
      else
        a = 64'($urandom_range(0, 63));
      xact(ld, st, a, {$urandom, $urandom}, 1'($urandom), 1'($urandom), rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
